// File: rtl/frame_buf_arbiter_if.sv
// frame_buf_arbiter_if: burst request/acknowledge bus between the frame-buffer
// arbiter (master) and the memory controller (slave).
interface frame_buf_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_len;
  logic              mem_ack;
  logic              mem_done;

  modport master (
    output mem_req, mem_we, mem_addr, mem_len,
    input  mem_ack, mem_done
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_len,
    output mem_ack, mem_done
  );
endinterface

// File: rtl/frame_buf_arbiter.sv
// frame_buf_arbiter: shares one memory port between the camera write stream
// (current frame) and the read-back stream (previous frame), ping-ponging two
// frame banks on every vsync rising edge.
module frame_buf_arbiter #(
  parameter int                ADDR_W      = 22,
  parameter int                BURST_LEN   = 64,
  parameter int                FRAME_WORDS = 76800,
  parameter logic [ADDR_W-1:0] BANK1_BASE  = ADDR_W'(32'h0002_0000),
  parameter int                RD_LOW_WM   = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                per_frame_vsync,
  input  logic [15:0]         wr_fifo_level,
  input  logic [15:0]         rd_fifo_level,
  frame_buf_arbiter_if.master mem,
  output logic                wr_bank,
  output logic                prev_valid
);

  // Counter width covers a full frame plus one burst so the saturating add never overflows.
  localparam int               CNT_W       = $clog2(FRAME_WORDS + BURST_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT   = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] BURST_CNT   = CNT_W'(BURST_LEN);
  localparam logic [15:0]      BURST_LVL   = 16'(BURST_LEN);
  localparam logic [15:0]      LOW_WM_LVL  = 16'(RD_LOW_WM);
  localparam logic [15:0]      RD_HEADROOM = 16'hFFFF - BURST_LVL;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_BURST,
    RD_REQ,
    RD_BURST
  } state_t;

  state_t            state_q, state_d;
  logic              vsync_dly_q, vsync_dly_d;
  logic              swap_pend_q, swap_pend_d;
  logic              wr_bank_q, wr_bank_d;
  logic              prev_valid_q, prev_valid_d;
  logic              last_wr_q, last_wr_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_len_q, mem_len_d;

  logic              vsync_edge;
  logic              wr_ok, rd_elig, rd_urgent, rd_ok;
  logic              grant_rd, grant_wr;
  logic [CNT_W-1:0]  wr_left, rd_left, wr_len, rd_len;
  logic [CNT_W-1:0]  wr_sum, rd_sum;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  // Work out which burst types qualify right now and what each would look like.
  always_comb begin
    vsync_edge = per_frame_vsync & ~vsync_dly_q;
    wr_left    = FRAME_CNT - wr_cnt_q;
    rd_left    = FRAME_CNT - rd_cnt_q;
    wr_len     = (wr_left < BURST_CNT) ? wr_left : BURST_CNT;
    rd_len     = (rd_left < BURST_CNT) ? rd_left : BURST_CNT;
    wr_addr    = (wr_bank_q ? BANK1_BASE : '0) + ADDR_W'(wr_cnt_q);
    rd_addr    = (wr_bank_q ? '0 : BANK1_BASE) + ADDR_W'(rd_cnt_q);
    wr_ok      = (wr_cnt_q < FRAME_CNT) &&
                 ((wr_fifo_level >= BURST_LVL) ||
                  ((wr_fifo_level != 16'd0) && (wr_left < BURST_CNT)));
    rd_elig    = prev_valid_q && (rd_cnt_q < FRAME_CNT);
    rd_urgent  = rd_elig && (rd_fifo_level < LOW_WM_LVL);
    rd_ok      = rd_elig && (rd_fifo_level <= RD_HEADROOM);
    grant_rd   = rd_urgent || (rd_ok && (!wr_ok || last_wr_q));
    grant_wr   = wr_ok && !grant_rd;
    wr_sum     = wr_cnt_q + CNT_W'(mem_len_q);
    rd_sum     = rd_cnt_q + CNT_W'(mem_len_q);
  end

  // Next-state logic: grant, handshake, count completed bursts and swap banks when idle.
  always_comb begin
    state_d      = state_q;
    vsync_dly_d  = per_frame_vsync;
    swap_pend_d  = swap_pend_q | vsync_edge;
    wr_bank_d    = wr_bank_q;
    prev_valid_d = prev_valid_q;
    last_wr_d    = last_wr_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_len_d    = mem_len_q;
    case (state_q)
      IDLE: begin
        if (swap_pend_q) begin
          wr_bank_d    = ~wr_bank_q;
          prev_valid_d = (wr_cnt_q == FRAME_CNT);
          wr_cnt_d     = '0;
          rd_cnt_d     = '0;
          swap_pend_d  = 1'b0;
        end else if (grant_rd) begin
          state_d    = RD_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = rd_addr;
          mem_len_d  = 16'(rd_len);
          last_wr_d  = 1'b0;
        end else if (grant_wr) begin
          state_d    = WR_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = wr_addr;
          mem_len_d  = 16'(wr_len);
          last_wr_d  = 1'b1;
        end
      end
      WR_REQ, RD_REQ: begin
        if (mem.mem_ack) begin
          state_d   = (state_q == WR_REQ) ? WR_BURST : RD_BURST;
          mem_req_d = 1'b0;
        end
      end
      WR_BURST: begin
        if (mem.mem_done) begin
          state_d  = IDLE;
          wr_cnt_d = (wr_sum > FRAME_CNT) ? FRAME_CNT : wr_sum;
        end
      end
      RD_BURST: begin
        if (mem.mem_done) begin
          state_d  = IDLE;
          rd_cnt_d = (rd_sum > FRAME_CNT) ? FRAME_CNT : rd_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      vsync_dly_q  <= 1'b0;
      swap_pend_q  <= 1'b0;
      wr_bank_q    <= 1'b0;
      prev_valid_q <= 1'b0;
      last_wr_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      vsync_dly_q  <= vsync_dly_d;
      swap_pend_q  <= swap_pend_d;
      wr_bank_q    <= wr_bank_d;
      prev_valid_q <= prev_valid_d;
      last_wr_q    <= last_wr_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_len_q    <= mem_len_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_we   = mem_we_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_len  = mem_len_q;
  assign wr_bank      = wr_bank_q;
  assign prev_valid   = prev_valid_q;

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// tb_frame_buf_arbiter: directed scenarios against a transaction-level model of
// the arbiter, using a 100-word frame so every frame ends in a truncated burst.
module tb_frame_buf_arbiter;

  localparam int FW = 100;
  localparam int BL = 64;
  localparam int B1 = 32'h0002_0000;
  localparam int WM = 32;

  logic        sys_clk;
  logic        sys_rst;
  logic        per_frame_vsync;
  logic [15:0] wr_fifo_level;
  logic [15:0] rd_fifo_level;
  logic        mem_ack;
  logic        mem_done;
  logic        wr_bank;
  logic        prev_valid;
  logic        mem_req;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [15:0] mem_len;

  int total_cnt = 0;
  int bad_cnt   = 0;

  frame_buf_arbiter_if #(.ADDR_W(22)) mif ();

  assign mif.mem_ack  = mem_ack;
  assign mif.mem_done = mem_done;
  assign mem_req      = mif.mem_req;
  assign mem_we       = mif.mem_we;
  assign mem_addr     = mif.mem_addr;
  assign mem_len      = mif.mem_len;

  frame_buf_arbiter #(
    .ADDR_W(22), .BURST_LEN(BL), .FRAME_WORDS(FW),
    .BANK1_BASE(22'h020000), .RD_LOW_WM(WM)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .per_frame_vsync(per_frame_vsync),
    .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
    .mem(mif), .wr_bank(wr_bank), .prev_valid(prev_valid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic [15:0] wl, input logic [15:0] rl);
    per_frame_vsync = vs;
    wr_fifo_level   = wl;
    rd_fifo_level   = rl;
  endtask

  // ---------------- model: one outstanding burst at a time ----------------
  typedef struct {
    bit active;
    bit acked;
    bit we;
    int addr;
    int len;
  } xfer_t;

  xfer_t m_x;
  bit    m_bank, m_prev, m_pend, m_vs_d, m_last_wr, model_on;
  int    m_wcnt, m_rcnt;

  initial begin
    m_x      = '{default: 0};
    model_on = 1'b0;
  end

  // The model advances on each rising edge from the inputs the bench drove on the falling edge.
  always @(posedge sys_clk) begin : model
    xfer_t x;
    bit    vs_rise, can_wr, can_rd, urgent, take_rd, take_wr;
    int    wl, rl, wleft, rleft;
    x = m_x;
    if (sys_rst) begin
      m_x       <= '{default: 0};
      m_bank    <= 1'b0;
      m_prev    <= 1'b0;
      m_pend    <= 1'b0;
      m_vs_d    <= 1'b0;
      m_last_wr <= 1'b0;
      m_wcnt    <= 0;
      m_rcnt    <= 0;
      model_on  <= 1'b1;
    end else begin
      vs_rise = per_frame_vsync && !m_vs_d;
      m_vs_d <= per_frame_vsync;
      if (!x.active && m_pend) begin
        m_bank <= !m_bank;
        m_prev <= (m_wcnt == FW);
        m_wcnt <= 0;
        m_rcnt <= 0;
        m_pend <= 1'b0;
      end else if (!x.active) begin
        m_pend <= vs_rise;
        wl     = int'(wr_fifo_level);
        rl     = int'(rd_fifo_level);
        wleft  = FW - m_wcnt;
        rleft  = FW - m_rcnt;
        can_wr = (wleft > 0) && ((wl >= BL) || (wl > 0 && wleft < BL));
        can_rd = m_prev && (rleft > 0) && (rl <= 65535 - BL);
        urgent = m_prev && (rleft > 0) && (rl < WM);
        take_rd = 1'b0;
        take_wr = 1'b0;
        if (urgent)              take_rd = 1'b1;
        else if (can_wr && can_rd) begin
          if (m_last_wr) take_rd = 1'b1;
          else           take_wr = 1'b1;
        end
        else if (can_wr)         take_wr = 1'b1;
        else if (can_rd)         take_rd = 1'b1;
        if (take_rd) begin
          x.active = 1; x.acked = 0; x.we = 0;
          x.addr = (m_bank ? 0 : B1) + m_rcnt;
          x.len  = (rleft < BL) ? rleft : BL;
          m_last_wr <= 1'b0;
        end else if (take_wr) begin
          x.active = 1; x.acked = 0; x.we = 1;
          x.addr = (m_bank ? B1 : 0) + m_wcnt;
          x.len  = (wleft < BL) ? wleft : BL;
          m_last_wr <= 1'b1;
        end
      end else begin
        m_pend <= m_pend | vs_rise;
        if (!x.acked) begin
          if (mem_ack) x.acked = 1;
        end else if (mem_done) begin
          if (x.we) m_wcnt <= (m_wcnt + x.len > FW) ? FW : m_wcnt + x.len;
          else      m_rcnt <= (m_rcnt + x.len > FW) ? FW : m_rcnt + x.len;
          x.active = 0;
        end
      end
      m_x <= x;
    end
  end

  // Compare every registered output against the model on each falling edge.
  always @(negedge sys_clk) begin
    if (model_on) begin
      checkOutput("cyc_req", {31'd0, mem_req}, {31'd0, m_x.active && !m_x.acked});
      checkOutput("cyc_bank", {31'd0, wr_bank}, {31'd0, m_bank});
      checkOutput("cyc_prev", {31'd0, prev_valid}, {31'd0, m_prev});
      if (m_x.active && !m_x.acked) begin
        checkOutput("cyc_we", {31'd0, mem_we}, {31'd0, m_x.we});
        checkOutput("cyc_addr", {10'd0, mem_addr}, m_x.addr);
        checkOutput("cyc_len", {16'd0, mem_len}, m_x.len);
      end
    end
  end

  // Wait (bounded) for a request, pin its fields, and optionally acknowledge it.
  task automatic waitReq(input string tag, input bit we, input int addr, input int len, input bit do_ack);
    int n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    if (mem_req === 1'b1) begin
      checkOutput({tag, "_we"}, {31'd0, mem_we}, {31'd0, we});
      checkOutput({tag, "_addr"}, {10'd0, mem_addr}, addr);
      checkOutput({tag, "_len"}, {16'd0, mem_len}, len);
      if (do_ack) begin
        mem_ack = 1'b1;
        @(negedge sys_clk);
        mem_ack = 1'b0;
      end
    end
  endtask

  task automatic finishBurst();
    repeat (2) @(negedge sys_clk);
    mem_done = 1'b1;
    @(negedge sys_clk);
    mem_done = 1'b0;
  endtask

  task automatic serveBurst(input string tag, input bit we, input int addr, input int len);
    waitReq(tag, we, addr, len, 1'b1);
    finishBurst();
  endtask

  task automatic pulseVsync();
    per_frame_vsync = 1'b1;
    @(negedge sys_clk);
    per_frame_vsync = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst  = 1'b1;
    mem_ack  = 1'b0;
    mem_done = 1'b0;
    applyStimulus(1'b0, 16'd0, 16'd1000);
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_addr", {10'd0, mem_addr}, 32'd0);
    checkOutput("rst_len", {16'd0, mem_len}, 32'd0);
    checkOutput("rst_bank", {31'd0, wr_bank}, 32'd0);
    checkOutput("rst_prev", {31'd0, prev_valid}, 32'd0);
    sys_rst = 1'b0;

    // First frame into bank 0: full burst then truncated tail, then writes stop.
    $display("[TB] first frame writes");
    applyStimulus(1'b0, 16'd64, 16'd1000);
    serveBurst("w0", 1'b1, 0, 64);
    serveBurst("w1", 1'b1, 64, 36);
    repeat (4) @(negedge sys_clk);
    checkOutput("wr_full_idle", {31'd0, mem_req}, 32'd0);

    // Complete frame swaps in: reads and writes alternate when neither is urgent.
    $display("[TB] swap to bank 1, alternating grants");
    pulseVsync();
    checkOutput("swap1_bank", {31'd0, wr_bank}, 32'd1);
    checkOutput("swap1_prev", {31'd0, prev_valid}, 32'd1);
    serveBurst("rr_r0", 1'b0, 0, 64);
    serveBurst("rr_w0", 1'b1, B1, 64);
    serveBurst("rr_r1", 1'b0, 64, 36);
    serveBurst("rr_w1", 1'b1, B1 + 64, 36);

    // Low read FIFO: reads win every time they qualify.
    $display("[TB] urgent reads");
    applyStimulus(1'b0, 16'd64, 16'd10);
    pulseVsync();
    checkOutput("swap2_bank", {31'd0, wr_bank}, 32'd0);
    checkOutput("swap2_prev", {31'd0, prev_valid}, 32'd1);
    serveBurst("urg_r0", 1'b0, B1, 64);
    serveBurst("urg_r1", 1'b0, B1 + 64, 36);
    serveBurst("urg_w0", 1'b1, 0, 64);
    serveBurst("urg_w1", 1'b1, 64, 36);

    // Two vsync edges during a write burst collapse into one deferred swap.
    $display("[TB] vsync during write burst");
    applyStimulus(1'b0, 16'd64, 16'hFFFF);
    pulseVsync();
    checkOutput("swap3_bank", {31'd0, wr_bank}, 32'd1);
    waitReq("mid_w0", 1'b1, B1, 64, 1'b1);
    pulseVsync();
    pulseVsync();
    checkOutput("mid_bank_hold", {31'd0, wr_bank}, 32'd1);
    finishBurst();
    checkOutput("done_bank_hold", {31'd0, wr_bank}, 32'd1);
    @(negedge sys_clk);
    checkOutput("swap4_bank", {31'd0, wr_bank}, 32'd0);
    checkOutput("swap4_prev", {31'd0, prev_valid}, 32'd0);
    checkOutput("swap4_no_grant", {31'd0, mem_req}, 32'd0);

    // Short frame discarded: no reads even with an empty read FIFO.
    $display("[TB] short frame, reads suppressed");
    applyStimulus(1'b0, 16'd64, 16'd0);
    serveBurst("sf_w0", 1'b1, 0, 64);
    serveBurst("sf_w1", 1'b1, 64, 36);
    repeat (4) @(negedge sys_clk);
    checkOutput("sf_no_read", {31'd0, mem_req}, 32'd0);

    // Reset while a read request is pending, then a stray done.
    $display("[TB] reset during read request");
    applyStimulus(1'b0, 16'd0, 16'd1000);
    pulseVsync();
    checkOutput("swap5_prev", {31'd0, prev_valid}, 32'd1);
    waitReq("rst_r0", 1'b0, 0, 64, 1'b0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    checkOutput("mid_rst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("mid_rst_bank", {31'd0, wr_bank}, 32'd0);
    mem_done = 1'b1;
    @(negedge sys_clk);
    mem_done = 1'b0;
    @(negedge sys_clk);
    checkOutput("stray_done_req", {31'd0, mem_req}, 32'd0);
    checkOutput("stray_done_prev", {31'd0, prev_valid}, 32'd0);
    applyStimulus(1'b0, 16'd64, 16'd1000);
    serveBurst("post_rst_w0", 1'b1, 0, 64);
    repeat (4) @(negedge sys_clk);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
